// File: rtl/fetch_ctrl.sv
// fetch_ctrl: sequential-PC fetch controller packing SS imem responses into one decode bundle.
//   clk, rst (async, active-low)
//   imem_addr/imem_rmask      : single-cycle request strobe (rmask=4'hF) and address
//   imem_rdata/imem_resp      : one-cycle response strobe with instruction word
//   redirect_valid/redirect_pc: flush buffered/in-flight fetches and restart at redirect_pc
//   queue_full                : downstream queue cannot take a bundle this cycle
//   out_push/out_inst/out_pc  : bundle push pulse and slot contents (slot 0 oldest)
module fetch_ctrl #(
    parameter int          SS       = 2,
    parameter logic [31:0] RESET_PC = 32'h6000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic [3:0]  imem_rmask,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        queue_full,
    output logic        out_push,
    output logic [31:0] out_inst [SS],
    output logic [31:0] out_pc   [SS]
);
    localparam int CW = $clog2(SS + 1);
    localparam logic [CW-1:0] FULL = CW'(SS);

    typedef enum logic [1:0] {IDLE, WAIT, WAIT_STALE} state_e;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] count_q, count_d, idx;
    logic [31:0]   slot_inst_q [SS];
    logic [31:0]   slot_pc_q   [SS];
    logic          push, space, resp_live, capture, issue;

    always_comb begin
        push      = (count_q == FULL) && !queue_full && !redirect_valid;
        space     = (count_q < FULL) || push;
        resp_live = (state_q != IDLE) && imem_resp;
        // A response that finds the bundle full and held is dropped with pc
        // left in place, so that PC is simply refetched once the bundle drains.
        capture   = (state_q == WAIT) && imem_resp && !redirect_valid && space;
        issue     = rst && !redirect_valid && space && ((state_q == IDLE) || resp_live);
        idx       = push ? '0 : count_q;
        pc_d      = redirect_valid ? redirect_pc : capture ? pc_q + 32'd4 : pc_q;
        count_d   = redirect_valid ? '0 : idx + CW'(capture);
        // A redirect with a request still in flight must swallow its response.
        state_d   = redirect_valid ? (((state_q != IDLE) && !imem_resp) ? WAIT_STALE : IDLE)
                  : issue ? WAIT : resp_live ? IDLE : state_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            count_q <= '0;
            for (int i = 0; i < SS; i++) begin
                slot_inst_q[i] <= '0;
                slot_pc_q[i]   <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            for (int i = 0; i < SS; i++) begin
                if (capture && (idx == CW'(i))) begin
                    slot_inst_q[i] <= imem_rdata;
                    slot_pc_q[i]   <= pc_q;
                end
            end
        end
    end

    // Back-to-back issue on a capture cycle already targets the incremented pc.
    assign imem_addr  = capture ? pc_q + 32'd4 : pc_q;
    assign imem_rmask = issue ? 4'hF : 4'h0;
    assign out_push   = push;
    assign out_inst   = slot_inst_q;
    assign out_pc     = slot_pc_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: randomized bench for fetch_ctrl against a queue-based fetch model.
module tb_fetch_ctrl;
    localparam int          SS  = 2;
    localparam logic [31:0] RPC = 32'h6000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata = '0;
    logic        imem_resp = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        queue_full = 1'b0;
    logic        out_push;
    logic [31:0] out_inst [SS];
    logic [31:0] out_pc   [SS];

    always #5 clk = ~clk;

    fetch_ctrl #(.SS(SS), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rmask(imem_rmask),
        .imem_rdata(imem_rdata), .imem_resp(imem_resp), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .queue_full(queue_full), .out_push(out_push),
        .out_inst(out_inst), .out_pc(out_pc)
    );

    int total = 0;
    int bad = 0;

    // model: fetch pointer, captured (pc,inst) pairs, in-flight request and whether it was flushed
    logic [31:0] m_pc = RPC;
    logic [31:0] b_pc[$];
    logic [31:0] b_inst[$];
    bit          m_out = 0;
    bit          m_stale = 0;

    // memory environment
    int          lat = 1;
    int          mem_left = 0;
    logic [31:0] mem_addr = '0;

    int          qf_pct = 0;
    int          rd_pct = 0;
    bit          rd_fix_en = 0;
    logic [31:0] rd_fix = '0;

    int          cyc = 0;
    int          n_issue = 0;
    int          npush = 0;
    int          push_cyc = -1;
    logic [31:0] first_addr = '0;
    logic [31:0] last_addr = '0;
    logic [31:0] log_pc[4];
    logic [31:0] log_inst0 = '0;
    logic [31:0] last_pc0 = '0;
    logic [31:0] last_pc1 = '0;

    function automatic logic [31:0] img(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_check();
        bit push, room, cap, iss;
        logic [31:0] ea;
        if (!rst) begin
            chk("rst_rmask", 32'(imem_rmask), 0);
            chk("rst_push", 32'(out_push), 0);
            chk("rst_slot", out_pc[0] | out_inst[SS-1], 0);
            m_pc = RPC; b_pc.delete(); b_inst.delete(); m_out = 0; m_stale = 0;
            return;
        end
        push = (b_pc.size() == SS) && !queue_full && !redirect_valid;
        room = (b_pc.size() < SS) || push;
        cap  = m_out && !m_stale && imem_resp && !redirect_valid && room;
        iss  = !redirect_valid && room && (!m_out || imem_resp);
        ea   = cap ? m_pc + 32'd4 : m_pc;
        chk("push", 32'(out_push), 32'(push));
        chk("rmask", 32'(imem_rmask), iss ? 32'hF : 32'h0);
        if (iss && imem_rmask == 4'hF) chk("addr", imem_addr, ea);
        if (imem_rmask == 4'hF) chk("one_outstanding", 32'(mem_left), 0);
        if (push && out_push) begin
            for (int i = 0; i < SS; i++) begin
                chk("bundle_pc", out_pc[i], b_pc[i]);
                chk("bundle_inst", out_inst[i], b_inst[i]);
            end
        end
        if (out_push) begin
            if (npush < 2) begin
                log_pc[2*npush] = out_pc[0];
                log_pc[2*npush+1] = out_pc[1];
            end
            if (npush == 0) begin
                push_cyc = cyc;
                log_inst0 = out_inst[0];
            end
            last_pc0 = out_pc[0];
            last_pc1 = out_pc[1];
            npush++;
        end
        if (imem_rmask == 4'hF) begin
            if (n_issue == 0) first_addr = imem_addr;
            last_addr = imem_addr;
            mem_addr = imem_addr;
            mem_left = lat;
            n_issue++;
        end
        if (push) begin b_pc.delete(); b_inst.delete(); end
        if (cap) begin b_pc.push_back(m_pc); b_inst.push_back(imem_rdata); m_pc += 32'd4; end
        if (redirect_valid) begin
            b_pc.delete(); b_inst.delete();
            m_pc = redirect_pc;
            if (m_out && !imem_resp) m_stale = 1;
            else begin m_out = 0; m_stale = 0; end
        end else begin
            if (imem_resp && m_out) begin m_out = 0; m_stale = 0; end
            if (iss) begin m_out = 1; m_stale = 0; end
        end
    endtask

    task automatic step();
        imem_resp = 1'b0;
        if (mem_left > 0) begin
            mem_left--;
            if (mem_left == 0) begin imem_resp = 1'b1; imem_rdata = img(mem_addr); end
        end
        if (!imem_resp) imem_rdata = $urandom;
        queue_full     = $urandom_range(99) < qf_pct;
        redirect_valid = $urandom_range(99) < rd_pct;
        redirect_pc    = rd_fix_en ? rd_fix : $urandom;
        @(negedge clk);
        model_check();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int k, n0, p0;
        logic [31:0] held;
        for (int i = 0; i < 4; i++) log_pc[i] = '0;
        repeat (3) step();
        rst = 1'b1;
        cyc = 0; n_issue = 0; npush = 0;
        // 1-cycle memory, never full
        lat = 1;
        repeat (12) step();
        chk("first_req", first_addr, RPC);
        chk("first_push_cyc", 32'(push_cyc), 3);
        chk("b0_pc0", log_pc[0], 32'h6000_0000);
        chk("b0_pc1", log_pc[1], 32'h6000_0004);
        chk("b1_pc0", log_pc[2], 32'h6000_0008);
        chk("b1_pc1", log_pc[3], 32'h6000_000C);
        chk("b0_inst0", log_inst0, img(32'h6000_0000));
        chk("issue_rate", 32'(n_issue), 12);
        // 3-cycle memory
        lat = 3;
        repeat (40) step();
        // backpressure held for 10 cycles right after a push
        lat = 1;
        p0 = npush; k = 0;
        while (npush == p0 && k < 10) begin step(); k++; end
        chk("qf_prepush", 32'(npush != p0), 1);
        qf_pct = 100;
        p0 = npush;
        repeat (5) step();
        held = out_pc[0];
        n0 = n_issue;
        repeat (5) step();
        chk("qf_nopush", 32'(npush), 32'(p0));
        chk("qf_stable", out_pc[0], held);
        chk("qf_noissue", 32'(n_issue), 32'(n0));
        qf_pct = 0;
        step();
        chk("qf_release_push", 32'(npush), 32'(p0 + 1));
        chk("qf_release_pc", last_pc0, held);
        // redirect one cycle after a request, stale response 2 cycles later
        lat = 3;
        n0 = n_issue; k = 0;
        while (n_issue == n0 && k < 10) begin step(); k++; end
        rd_pct = 100; rd_fix_en = 1; rd_fix = 32'h6000_1000;
        step();
        rd_pct = 0;
        n0 = n_issue; k = 0;
        while (n_issue == n0 && k < 10) begin step(); k++; end
        chk("redir_next_req", last_addr, 32'h6000_1000);
        p0 = npush; k = 0;
        while (npush == p0 && k < 30) begin step(); k++; end
        chk("redir_bundle0", last_pc0, 32'h6000_1000);
        chk("redir_bundle1", last_pc1, 32'h6000_1004);
        // redirect coincident with a response while one slot is filled
        lat = 1; k = 0;
        while (!(b_pc.size() == 1 && mem_left == 1) && k < 20) begin step(); k++; end
        chk("setup_count1", 32'(b_pc.size()), 1);
        rd_pct = 100; rd_fix = 32'h7000_0000;
        p0 = npush;
        step();
        rd_pct = 0;
        chk("redir_resp_nopush", 32'(npush), 32'(p0));
        n0 = n_issue;
        step();
        chk("redir_resp_issue", 32'(n_issue), 32'(n0 + 1));
        chk("redir_resp_addr", last_addr, 32'h7000_0000);
        rd_fix_en = 0;
        // randomized traffic
        qf_pct = 30; rd_pct = 5;
        for (int i = 0; i < 1500; i++) begin
            lat = $urandom_range(1, 4);
            step();
        end
        qf_pct = 0; rd_pct = 0;
        // reset in the middle of an outstanding request, late response lands after reset
        lat = 5;
        n0 = n_issue; k = 0;
        while (n_issue == n0 && k < 10) begin step(); k++; end
        step();
        rst = 1'b0;
        repeat (2) step();
        mem_left = 1;
        rst = 1'b1;
        lat = 1;
        n0 = n_issue;
        step();
        chk("post_rst_issue", 32'(n_issue), 32'(n0 + 1));
        chk("post_rst_addr", last_addr, RPC);
        p0 = npush; k = 0;
        while (npush == p0 && k < 10) begin step(); k++; end
        chk("post_rst_b0", last_pc0, RPC);
        chk("post_rst_b1", last_pc1, RPC + 32'd4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
